eespfal_switch_sequencer: RTL and testbench
===========================================

# eespfal_switch_sequencer

Digital controller that sequences the 4-bit EESPFAL adiabatic switch macro. It accepts one operand pair (x, k) per transaction and drives the dual-rail operands. It then generates the discharge, evaluate and recover phases on the per-bit CLK/Dis lines and Dis_Phase, samples the dual-rail result s/s_bar, and returns it to the host with a rail-integrity flag. It sits between the user-project digital logic and the analog macro instance.

## Interface
- BIT_SIZE, 4, bits per operand; sets the width of every per-bit vector.
- DIS_CYCLES, 2, discharge phase length in cycles; must be ≥1.
- PHASE_CYCLES, 4, length in cycles of the evaluate phase and of the recover phase; must be ≥1.

- clk  input  1  system clock.
- rst_n  input  1  reset; synchronous, active-low.
- bit_en  input  BIT_SIZE  per-bit enable; sampled on accept.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  sequencer can accept an operand pair.
- in_x  input  BIT_SIZE  operand x.
- in_k  input  BIT_SIZE  operand k (key).
- out_valid  output  1  result valid.
- out_ready  input  1  host accepts the result.
- out_s  output  BIT_SIZE  sampled s.
- out_err  output  BIT_SIZE  per-bit rail fault (s_i equal to s_bar_i).
- sw_clk  output  BIT_SIZE  to macro CLK.
- sw_dis  output  BIT_SIZE  to macro Dis.
- sw_dis_phase  output  1  to macro Dis_Phase.
- sw_x, sw_x_bar, sw_k, sw_k_bar  output  BIT_SIZE each  dual-rail operands.
- s_i, s_bar_i  input  BIT_SIZE each  macro outputs s/s_bar.

## Operation
- States:
  - IDLE → LOAD on in_valid && in_ready.
  - LOAD (1 cycle) → DISCH.
  - DISCH (DIS_CYCLES) → EVAL.
  - EVAL (PHASE_CYCLES) → SAMPLE.
  - SAMPLE (1 cycle) → RECOV.
  - RECOV (PHASE_CYCLES) → DONE.
  - DONE → IDLE on out_ready.
- in_ready = 1 only in IDLE. On accept, x, k and bit_en are latched as en_q.
- Rails:
  - From LOAD through RECOV: sw_x = x_q & en_q; sw_x_bar = ~x_q & en_q. sw_k and sw_k_bar follow the same rule.
  - In IDLE and DONE all rails are 0 (null spacer).
  - Disabled bits are 0 on both rails at all times.
- Phase lines:
  - sw_dis = en_q in DISCH, else 0.
  - sw_dis_phase = 1 in DISCH, else 0.
  - sw_clk = en_q in EVAL and SAMPLE, else 0.
  - sw_dis and sw_clk are never high in the same cycle.
- SAMPLE captures out_s = s_i & en_q and out_err = (s_i ~^ s_bar_i) & en_q.
- Outputs held:
  - out_valid is 1 in DONE only. out_s and out_err hold until the next SAMPLE.
  - out_valid stays high while out_ready is low; no result is dropped.
- Simultaneous events: out_ready in DONE moves the state to IDLE. An in_valid on that same edge is not accepted; it is accepted one cycle later, in IDLE.
- Counter: a single down-counter, width $clog2(max(DIS_CYCLES, PHASE_CYCLES)+1). It is loaded on each phase entry and the phase exits when the count reaches 1.

## Timing
- All outputs are registered.
- Reset values: all outputs 0, including in_ready and out_valid. State = IDLE. in_ready rises in the first cycle after rst_n goes high.
- Accept at edge T gives these state entries:
  - LOAD at T+1
  - DISCH at T+2
  - EVAL at T+2+D
  - SAMPLE at T+2+D+P
  - RECOV at T+3+D+P
  - DONE at T+3+D+2P
- With the defaults, out_valid is first high at T+13.
- Throughput: at most one transaction per 4+D+2P cycles.
- Reset mid-operation: on the next edge with rst_n low, all phase lines and rails go to 0 and the state goes to IDLE. The in-flight result is discarded and out_valid is not asserted.
- s_i and s_bar_i have settled for PHASE_CYCLES cycles of evaluate before sampling; no synchronizer is used.

## Configuration
- EESPFAL_SEQ_RAIL_CHECK_EN:
  - Defined: out_err is computed as above.
  - Undefined: out_err is tied to 0, s_bar_i is unused, and the XNOR logic is removed.
  - The state sequence and latency are identical in both cases.

## Structure
- Package eespfal_seq_pkg holds:
  - the state enum (IDLE, LOAD, DISCH, EVAL, SAMPLE, RECOV, DONE);
  - default DIS_CYCLES and PHASE_CYCLES constants;
  - a function returning the counter width.
- Sub-module eespfal_phase_timer: a loadable down-counter with a last-cycle flag, instantiated once.

## Test plan
- Basic transaction: bit_en=F, x=A, k=3, model returns s_i=x^k=9 and s_bar_i=6 → out_s=9, out_err=0, out_valid at T+13.
- Phase sequencing: check that sw_dis=F and sw_dis_phase=1 for exactly 2 cycles, then sw_clk=F for exactly 5 cycles. sw_dis and sw_clk never overlap; rails are 0 in IDLE and DONE.
- Partial enable: bit_en=5, x=F, k=0 → sw_x=5, sw_x_bar=0, sw_k=0, sw_k_bar=5, sw_clk=5, out_s=5. Bits 1 and 3 stay 0 everywhere.
- Rail fault: with the macro defined, s_i=F and s_bar_i=C → out_err=C. With the macro undefined → out_err=0.
- Backpressure and reset:
  - Hold out_ready=0 for 10 cycles → out_valid and out_s stay stable and in_ready=0.
  - Then assert out_ready together with in_valid → accept happens one cycle later.
  - Drop rst_n in EVAL → the next edge has all outputs 0, and no out_valid is produced for the aborted transaction.

Source files
------------

// File: rtl/eespfal_seq_pkg.sv
// Shared types and constants for the EESPFAL switch sequencer:
// state enum, default phase lengths and the phase-counter width helper.
package eespfal_seq_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    DISCH  = 3'd2,
    EVAL   = 3'd3,
    SAMPLE = 3'd4,
    RECOV  = 3'd5,
    DONE   = 3'd6
  } seq_state_e;

  localparam int DEF_BIT_SIZE     = 4;
  localparam int DEF_DIS_CYCLES   = 2;
  localparam int DEF_PHASE_CYCLES = 4;

  // Width needed to hold the longest phase length loaded into the counter.
  function automatic int cnt_width(input int dis_cycles, input int phase_cycles);
    int longest;
    longest = (dis_cycles > phase_cycles) ? dis_cycles : phase_cycles;
    return $clog2(longest + 1);
  endfunction

endpackage

// File: rtl/eespfal_phase_timer.sv
// Loadable down-counter used to time each sequencer phase.
// last is high while the count equals 1, i.e. in the final cycle of a phase.
module eespfal_phase_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         last
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: reload on phase entry, otherwise count down and rest at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last = (cnt_q == W'(1));

endmodule

// File: rtl/eespfal_switch_sequencer.sv
// Sequencer for the EESPFAL adiabatic switch macro: latches one (x, k) pair,
// drives dual-rail operands, runs discharge / evaluate / sample / recover
// phases and hands the sampled result back with a per-bit rail-fault flag.
// Optional feature macro: EESPFAL_SEQ_RAIL_CHECK_EN (rail-integrity check on
// s_i / s_bar_i; when undefined out_err is tied to 0 and s_bar_i is unused).
//
// Handshakes: a transfer happens on a clock edge where valid and ready are
// both high; valid holds with stable data until that edge, and ready never
// depends combinationally on valid.
module eespfal_switch_sequencer
  import eespfal_seq_pkg::*;
#(
  parameter int BIT_SIZE     = DEF_BIT_SIZE,
  parameter int DIS_CYCLES   = DEF_DIS_CYCLES,
  parameter int PHASE_CYCLES = DEF_PHASE_CYCLES
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [BIT_SIZE-1:0] bit_en,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [BIT_SIZE-1:0] in_x,
  input  logic [BIT_SIZE-1:0] in_k,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [BIT_SIZE-1:0] out_s,
  output logic [BIT_SIZE-1:0] out_err,
  output logic [BIT_SIZE-1:0] sw_clk,
  output logic [BIT_SIZE-1:0] sw_dis,
  output logic                sw_dis_phase,
  output logic [BIT_SIZE-1:0] sw_x,
  output logic [BIT_SIZE-1:0] sw_x_bar,
  output logic [BIT_SIZE-1:0] sw_k,
  output logic [BIT_SIZE-1:0] sw_k_bar,
  input  logic [BIT_SIZE-1:0] s_i,
  input  logic [BIT_SIZE-1:0] s_bar_i
);

  localparam int CW = cnt_width(DIS_CYCLES, PHASE_CYCLES);

  seq_state_e state_q, state_d;

  logic [BIT_SIZE-1:0] x_q, x_d;
  logic [BIT_SIZE-1:0] k_q, k_d;
  logic [BIT_SIZE-1:0] en_q, en_d;

  logic                in_ready_q, in_ready_d;
  logic                out_valid_q, out_valid_d;
  logic [BIT_SIZE-1:0] out_s_q, out_s_d;
  logic [BIT_SIZE-1:0] sw_clk_q, sw_clk_d;
  logic [BIT_SIZE-1:0] sw_dis_q, sw_dis_d;
  logic                sw_dis_phase_q, sw_dis_phase_d;
  logic [BIT_SIZE-1:0] sw_x_q, sw_x_d;
  logic [BIT_SIZE-1:0] sw_x_bar_q, sw_x_bar_d;
  logic [BIT_SIZE-1:0] sw_k_q, sw_k_d;
  logic [BIT_SIZE-1:0] sw_k_bar_q, sw_k_bar_d;

  logic          accept;
  logic          rails_on;
  logic          timer_load;
  logic [CW-1:0] timer_val;
  logic          timer_last;

  // Single shared phase counter, reloaded on every timed phase entry.
  eespfal_phase_timer #(
    .W(CW)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (timer_load),
    .load_val (timer_val),
    .last     (timer_last)
  );

  // Next-state logic and phase-counter loads.
  always_comb begin
    state_d    = state_q;
    timer_load = 1'b0;
    timer_val  = '0;
    accept     = in_valid && in_ready_q;
    unique case (state_q)
      IDLE: begin
        if (accept) state_d = LOAD;
      end
      LOAD: begin
        state_d    = DISCH;
        timer_load = 1'b1;
        timer_val  = CW'(DIS_CYCLES);
      end
      DISCH: begin
        if (timer_last) begin
          state_d    = EVAL;
          timer_load = 1'b1;
          timer_val  = CW'(PHASE_CYCLES);
        end
      end
      EVAL: begin
        if (timer_last) state_d = SAMPLE;
      end
      SAMPLE: begin
        state_d    = RECOV;
        timer_load = 1'b1;
        timer_val  = CW'(PHASE_CYCLES);
      end
      RECOV: begin
        if (timer_last) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output values for the coming state; registering them keeps every port a flop output.
  always_comb begin
    x_d  = accept ? in_x   : x_q;
    k_d  = accept ? in_k   : k_q;
    en_d = accept ? bit_en : en_q;

    rails_on = (state_d inside {LOAD, DISCH, EVAL, SAMPLE, RECOV});

    sw_x_d     = rails_on ? ( x_d & en_d) : '0;
    sw_x_bar_d = rails_on ? (~x_d & en_d) : '0;
    sw_k_d     = rails_on ? ( k_d & en_d) : '0;
    sw_k_bar_d = rails_on ? (~k_d & en_d) : '0;

    sw_dis_d       = (state_d == DISCH) ? en_d : '0;
    sw_dis_phase_d = (state_d == DISCH);
    sw_clk_d       = (state_d inside {EVAL, SAMPLE}) ? en_d : '0;

    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);

    out_s_d = (state_q == SAMPLE) ? (s_i & en_q) : out_s_q;
  end

  // State, latched operands and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      x_q            <= '0;
      k_q            <= '0;
      en_q           <= '0;
      in_ready_q     <= 1'b0;
      out_valid_q    <= 1'b0;
      out_s_q        <= '0;
      sw_clk_q       <= '0;
      sw_dis_q       <= '0;
      sw_dis_phase_q <= 1'b0;
      sw_x_q         <= '0;
      sw_x_bar_q     <= '0;
      sw_k_q         <= '0;
      sw_k_bar_q     <= '0;
    end else begin
      state_q        <= state_d;
      x_q            <= x_d;
      k_q            <= k_d;
      en_q           <= en_d;
      in_ready_q     <= in_ready_d;
      out_valid_q    <= out_valid_d;
      out_s_q        <= out_s_d;
      sw_clk_q       <= sw_clk_d;
      sw_dis_q       <= sw_dis_d;
      sw_dis_phase_q <= sw_dis_phase_d;
      sw_x_q         <= sw_x_d;
      sw_x_bar_q     <= sw_x_bar_d;
      sw_k_q         <= sw_k_d;
      sw_k_bar_q     <= sw_k_bar_d;
    end
  end

`ifdef EESPFAL_SEQ_RAIL_CHECK_EN
  logic [BIT_SIZE-1:0] out_err_q, out_err_d;

  // A healthy dual-rail bit has exactly one rail high; equal rails flag a fault.
  always_comb begin
    out_err_d = (state_q == SAMPLE) ? ((s_i ~^ s_bar_i) & en_q) : out_err_q;
  end

  // Rail-fault register, captured alongside out_s.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_err_q <= '0;
    end else begin
      out_err_q <= out_err_d;
    end
  end

  assign out_err = out_err_q;
`else
  logic unused_s_bar;
  assign unused_s_bar = ^s_bar_i;
  assign out_err      = '0;
`endif

  assign in_ready     = in_ready_q;
  assign out_valid    = out_valid_q;
  assign out_s        = out_s_q;
  assign sw_clk       = sw_clk_q;
  assign sw_dis       = sw_dis_q;
  assign sw_dis_phase = sw_dis_phase_q;
  assign sw_x         = sw_x_q;
  assign sw_x_bar     = sw_x_bar_q;
  assign sw_k         = sw_k_q;
  assign sw_k_bar     = sw_k_bar_q;

endmodule

// File: tb/tb_eespfal_switch_sequencer.sv
// Testbench for eespfal_switch_sequencer: directed and randomized transactions
// checked cycle by cycle against a timeline model derived from phase lengths.
module tb_eespfal_switch_sequencer;

  localparam int BW     = 4;
  localparam int D      = 2;
  localparam int P      = 4;
  localparam int T_DONE = 3 + D + 2 * P;  // cycle offset of DONE after accept

`ifdef EESPFAL_SEQ_RAIL_CHECK_EN
  localparam bit RAIL_CHECK = 1'b1;
`else
  localparam bit RAIL_CHECK = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [BW-1:0] bit_en   = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [BW-1:0] in_x     = '0;
  logic [BW-1:0] in_k     = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [BW-1:0] out_s, out_err;
  logic [BW-1:0] sw_clk, sw_dis;
  logic          sw_dis_phase;
  logic [BW-1:0] sw_x, sw_x_bar, sw_k, sw_k_bar;
  logic [BW-1:0] s_i     = '0;
  logic [BW-1:0] s_bar_i = '0;

  eespfal_switch_sequencer #(
    .BIT_SIZE     (BW),
    .DIS_CYCLES   (D),
    .PHASE_CYCLES (P)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bit_en       (bit_en),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_x         (in_x),
    .in_k         (in_k),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_s        (out_s),
    .out_err      (out_err),
    .sw_clk       (sw_clk),
    .sw_dis       (sw_dis),
    .sw_dis_phase (sw_dis_phase),
    .sw_x         (sw_x),
    .sw_x_bar     (sw_x_bar),
    .sw_k         (sw_k),
    .sw_k_bar     (sw_k_bar),
    .s_i          (s_i),
    .s_bar_i      (s_bar_i)
  );

  // ---------------- scoreboard state ----------------
  int n_assert = 0;
  int n_fail   = 0;
  logic [BW-1:0] prev_s   = '0;
  logic [BW-1:0] prev_err = '0;
  logic [BW-1:0] exp_q[$];  // pending expected results (s then err)

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic e_rdy, input logic e_vld,
                          input logic [BW-1:0] e_x, input logic [BW-1:0] e_xb,
                          input logic [BW-1:0] e_k, input logic [BW-1:0] e_kb,
                          input logic [BW-1:0] e_dis, input logic e_dp,
                          input logic [BW-1:0] e_clk, input logic [BW-1:0] e_s,
                          input logic [BW-1:0] e_err);
    chk({tag, ".in_ready"},  32'(in_ready),     32'(e_rdy));
    chk({tag, ".out_valid"}, 32'(out_valid),    32'(e_vld));
    chk({tag, ".sw_x"},      32'(sw_x),         32'(e_x));
    chk({tag, ".sw_x_bar"},  32'(sw_x_bar),     32'(e_xb));
    chk({tag, ".sw_k"},      32'(sw_k),         32'(e_k));
    chk({tag, ".sw_k_bar"},  32'(sw_k_bar),     32'(e_kb));
    chk({tag, ".sw_dis"},    32'(sw_dis),       32'(e_dis));
    chk({tag, ".dis_phase"}, 32'(sw_dis_phase), 32'(e_dp));
    chk({tag, ".sw_clk"},    32'(sw_clk),       32'(e_clk));
    chk({tag, ".out_s"},     32'(out_s),        32'(e_s));
    chk({tag, ".out_err"},   32'(out_err),      32'(e_err));
    chk({tag, ".overlap"},   32'(sw_dis & sw_clk), 32'(0));
  endtask

  // One full transaction. hold = extra DONE cycles with out_ready low;
  // chain = raise in_valid together with out_ready on the release edge.
  task automatic run_txn(input string tag, input logic [BW-1:0] en, input logic [BW-1:0] x,
                         input logic [BW-1:0] k, input logic [BW-1:0] s,
                         input logic [BW-1:0] sb, input int hold, input bit chain);
    int w;
    logic [BW-1:0] es, ee, ex, exb, ek, ekb, edis, eclk, cur_s, cur_e;
    bit rails, disph, clkph, done;
    w = 0;
    while (!in_ready && w < 20) begin
      step();
      w++;
    end
    chk({tag, ".idle_wait"}, 32'(in_ready), 32'(1));
    in_valid = 1'b1;
    bit_en   = en;
    in_x     = x;
    in_k     = k;
    s_i      = s;
    s_bar_i  = sb;
    exp_q.push_back(s & en);
    exp_q.push_back(RAIL_CHECK ? (~(s ^ sb) & en) : '0);
    step();  // accept edge
    in_valid = 1'b0;
    es = exp_q.pop_front();
    ee = exp_q.pop_front();
    for (int n = 1; n <= T_DONE + hold; n++) begin
      rails = (n < T_DONE);
      disph = (n >= 2) && (n < 2 + D);
      clkph = (n >= 2 + D) && (n <= 2 + D + P);
      done  = (n >= T_DONE);
      ex    = rails ? ( x & en) : '0;
      exb   = rails ? (~x & en) : '0;
      ek    = rails ? ( k & en) : '0;
      ekb   = rails ? (~k & en) : '0;
      edis  = disph ? en : '0;
      eclk  = clkph ? en : '0;
      cur_s = (n >= 3 + D + P) ? es : prev_s;
      cur_e = (n >= 3 + D + P) ? ee : prev_err;
      chk_outs($sformatf("%s.c%0d", tag, n), 1'b0, done, ex, exb, ek, ekb,
               edis, disph, eclk, cur_s, cur_e);
      if (n == T_DONE + hold) begin
        out_ready = 1'b1;
        if (chain) in_valid = 1'b1;
      end
      step();
    end
    out_ready = 1'b0;
    // Back in IDLE: a same-edge in_valid must not have been accepted.
    chk_outs({tag, ".idle"}, 1'b1, 1'b0, '0, '0, '0, '0, '0, 1'b0, '0, es, ee);
    prev_s   = es;
    prev_err = ee;
  endtask

  // Accept a transaction, then pull reset during the evaluate phase.
  task automatic abort_txn(input logic [BW-1:0] en, input logic [BW-1:0] x,
                           input logic [BW-1:0] k);
    int w;
    w = 0;
    while (!in_ready && w < 20) begin
      step();
      w++;
    end
    chk("abort.idle_wait", 32'(in_ready), 32'(1));
    in_valid = 1'b1;
    bit_en   = en;
    in_x     = x;
    in_k     = k;
    step();
    in_valid = 1'b0;
    for (int n = 1; n < 2 + D + 1; n++) step();  // now inside EVAL
    chk("abort.in_eval_clk", 32'(sw_clk), 32'(en));
    rst_n = 1'b0;
    step();
    chk_outs("abort.rst", 1'b0, 1'b0, '0, '0, '0, '0, '0, 1'b0, '0, '0, '0);
    rst_n = 1'b1;
    step();
    chk_outs("abort.rel", 1'b1, 1'b0, '0, '0, '0, '0, '0, 1'b0, '0, '0, '0);
    for (int n = 0; n < T_DONE + 2; n++) begin
      step();
      chk($sformatf("abort.no_valid%0d", n), 32'(out_valid), 32'(0));
    end
    prev_s   = '0;
    prev_err = '0;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [BW-1:0] r_en, r_x, r_k, r_s, r_sb;

    // Reset: every output low, in_ready included.
    rst_n = 1'b0;
    repeat (3) step();
    chk_outs("reset", 1'b0, 1'b0, '0, '0, '0, '0, '0, 1'b0, '0, '0, '0);
    rst_n = 1'b1;
    step();
    chk_outs("reset_rel", 1'b1, 1'b0, '0, '0, '0, '0, '0, 1'b0, '0, '0, '0);

    // Basic: s = x ^ k, s_bar its complement.
    run_txn("basic", 4'hF, 4'hA, 4'h3, 4'h9, 4'h6, 0, 1'b0);
    // Partial enable: bits 1 and 3 never move.
    run_txn("partial", 4'h5, 4'hF, 4'h0, 4'hF, 4'h0, 0, 1'b0);
    // Rail fault on bits 2 and 3.
    run_txn("rail_fault", 4'hF, 4'h3, 4'h5, 4'hF, 4'hC, 0, 1'b0);
    // Backpressure for 10 cycles, then release together with a new in_valid.
    run_txn("backpressure", 4'hF, 4'h6, 4'h9, 4'h5, 4'hA, 10, 1'b1);
    run_txn("chained", 4'hB, 4'h7, 4'h2, 4'h5, 4'hA, 0, 1'b0);

    // Randomized transactions.
    for (int i = 0; i < 10; i++) begin
      r_en = BW'($urandom_range(0, 15));
      r_x  = BW'($urandom_range(0, 15));
      r_k  = BW'($urandom_range(0, 15));
      r_s  = BW'($urandom_range(0, 15));
      r_sb = ($urandom_range(0, 2) == 0) ? BW'($urandom_range(0, 15)) : ~r_s;
      run_txn($sformatf("rand%0d", i), r_en, r_x, r_k, r_s, r_sb,
              int'($urandom_range(0, 3)), (i < 9) ? bit'($urandom_range(0, 1)) : 1'b0);
    end

    // Reset in the middle of evaluate, then a clean transaction afterwards.
    abort_txn(4'hF, 4'hC, 4'h5);
    run_txn("after_abort", 4'hE, 4'h1, 4'h8, 4'h9, 4'h6, 1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
